// File: rtl/gaussian_conv_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gaussian_conv_ctrl : steps an external 5x5 coefficient ROM over one latched
// pixel window, multiply-accumulates, then rounds/saturates to one pixel.
// Revision 1.0
// ---------------------------------------------------------------------------
module gaussian_conv_ctrl #(
  parameter int PIX_W  = 8,
  parameter int COEF_W = 16,
  parameter int FRAC   = 12,
  parameter int ACC_W  = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  win_valid,
  output logic                  win_ready,
  input  logic [25*PIX_W-1:0]   win_data,
  output logic [4:0]            rom_addr,
  input  logic [COEF_W-1:0]     rom_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PIX_W-1:0]      out_pixel,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    RND  = 2'd2,
    OUT  = 2'd3
  } state_t;

  localparam int            NTAPS    = 25;
  localparam logic [4:0]    LAST_IDX = 5'd24;
  localparam logic [ACC_W:0] HALF    = (ACC_W+1)'(1) << (FRAC-1);
  localparam logic [ACC_W:0] PIX_MAX = (ACC_W+1)'((1 << PIX_W) - 1);

  state_t                    state;
  logic [4:0]                idx;
  logic [ACC_W-1:0]          acc;
  logic [PIX_W-1:0]          taps [NTAPS];
  logic [PIX_W+COEF_W-1:0]   prod;
  logic [ACC_W:0]            rounded;
  logic [ACC_W:0]            shifted;
  logic [PIX_W-1:0]          sat_pixel;
  logic                      accept;

  assign accept   = (state == IDLE) && win_valid && win_ready && !flush;
  assign rom_addr = (state == MAC) ? idx : 5'd0;
  assign busy     = (state != IDLE);

  always_comb begin
    prod      = (PIX_W+COEF_W)'(taps[idx]) * (PIX_W+COEF_W)'(rom_data);
    rounded   = {1'b0, acc} + HALF;
    shifted   = rounded >> FRAC;
    sat_pixel = (shifted > PIX_MAX) ? PIX_MAX[PIX_W-1:0] : shifted[PIX_W-1:0];
  end

  // Window storage is data-path only, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < NTAPS; k++) begin
        taps[k] <= win_data[PIX_W*k +: PIX_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= 5'd0;
      acc       <= '0;
      out_pixel <= '0;
      out_valid <= 1'b0;
      win_ready <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      idx       <= 5'd0;
      acc       <= '0;
      out_pixel <= '0;
      out_valid <= 1'b0;
      win_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (win_valid && win_ready) begin
            acc       <= '0;
            idx       <= 5'd0;
            win_ready <= 1'b0;
            state     <= MAC;
          end else begin
            win_ready <= 1'b1;
          end
        end
        MAC: begin
          acc <= acc + ACC_W'(prod);
          if (idx == LAST_IDX) begin
            idx   <= 5'd0;
            state <= RND;
          end else begin
            idx <= idx + 5'd1;
          end
        end
        RND: begin
          out_pixel <= sat_pixel;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            win_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gaussian_conv_ctrl.sv
`default_nettype none
// tb_gaussian_conv_ctrl : randomized + directed windows, expected pixels
// queued at accept and compared by an independent output monitor.
module tb_gaussian_conv_ctrl;

  localparam int PIX_W  = 8;
  localparam int COEF_W = 16;
  localparam int WIN_W  = 25*PIX_W;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               flush = 1'b0;
  logic               win_valid = 1'b0;
  logic               out_ready = 1'b1;
  logic [WIN_W-1:0]   win_data = '0;
  logic               win_ready, out_valid, busy;
  logic [4:0]         rom_addr;
  logic [COEF_W-1:0]  rom_data;
  logic [PIX_W-1:0]   out_pixel;

  int       errors = 0;
  int       checks = 0;
  int       exp_q[$];
  bit       ovr = 1'b0;
  realtime  t_acc;

  int weights [25] = '{2, 4, 5, 4, 2,
                       4, 9, 12, 9, 4,
                       5, 12, 15, 12, 5,
                       4, 9, 12, 9, 4,
                       2, 4, 5, 4, 2};

  gaussian_conv_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_data  (win_data),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pixel (out_pixel),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Q4.12 coefficient of kernel weight w/159, rounded to nearest
  function automatic int coef(int k);
    return (weights[k] * 4096 + 79) / 159;
  endfunction

  always_comb begin
    if (ovr)                rom_data = 16'd2000;
    else if (rom_addr < 25) rom_data = COEF_W'(coef(int'(rom_addr)));
    else                    rom_data = 16'hFFFF;
  end

  function automatic int model(logic [WIN_W-1:0] d, bit o);
    longint acc = 0;
    for (int k = 0; k < 25; k++)
      acc += longint'(d[8*k +: 8]) * longint'(o ? 2000 : coef(k));
    acc = acc % (longint'(1) << 24);
    acc = (acc + 2048) / 4096;
    return (acc > 255) ? 255 : int'(acc);
  endfunction

  function automatic logic [WIN_W-1:0] fill(int v);
    logic [WIN_W-1:0] r;
    for (int k = 0; k < 25; k++) r[8*k +: 8] = 8'(v);
    return r;
  endfunction

  function automatic logic [WIN_W-1:0] rand_win();
    logic [WIN_W-1:0] r;
    for (int k = 0; k < 25; k++) r[8*k +: 8] = 8'($urandom);
    return r;
  endfunction

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got pixel %0d required no output", out_pixel);
      end else begin
        chk("out_pixel", longint'(out_pixel), longint'(exp_q.pop_front()));
      end
    end
  end

  task automatic do_accept(input logic [WIN_W-1:0] d, output bit ok);
    int n = 0;
    win_data  = d;
    win_valid = 1'b1;
    while (!win_ready && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (!win_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: win_ready got 0 required 1");
      win_valid = 1'b0;
      ok = 1'b0;
      return;
    end
    @(posedge clk);
    t_acc = $realtime;
    #1;
    win_valid = 1'b0;
    win_data  = rand_win();
    exp_q.push_back(model(d, ovr));
    ok = 1'b1;
  endtask

  task automatic run_window(input logic [WIN_W-1:0] d, input bit o, input int hold);
    bit ok;
    int good = 0;
    int n = 0;
    logic [7:0] held;
    ovr       = o;
    out_ready = (hold == 0);
    do_accept(d, ok);
    if (!ok) begin
      out_ready = 1'b1;
      return;
    end
    for (int j = 0; j < 25; j++) begin
      if (rom_addr == 5'(j) && busy && !out_valid) good++;
      if (j < 24) begin @(posedge clk); #1; end
    end
    chk("rom_addr_seq", good, 25);
    @(posedge clk); #1;
    chk("rnd_state", {rom_addr, out_valid, busy}, {5'd0, 1'b0, 1'b1});
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("out_latency", n, 1);
    if (hold > 0) begin
      held = out_pixel;
      good = 0;
      for (int j = 0; j < hold; j++) begin
        if (j == 0) begin
          win_valid = 1'b1;
          win_data  = rand_win();
        end
        @(posedge clk); #1;
        win_valid = 1'b0;
        if (out_valid && out_pixel == held && !win_ready && busy && rom_addr == 5'd0) good++;
      end
      chk("backpressure_hold", good, hold);
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("post_handshake", {out_valid, win_ready, busy}, 3'b010);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int      n;
    bit      ok;
    realtime t_a;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {out_valid, win_ready, busy, rom_addr, out_pixel}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("win_ready_after_reset", win_ready, 1);

    run_window(fill(100), 1'b0, 0);
    t_a = t_acc;
    run_window(fill(200) & (WIN_W'(8'hFF) << (8*12)), 1'b0, 0);
    chk("throughput_cycles", longint'((t_acc - t_a) / 10.0), 28);
    run_window(fill(255), 1'b0, 0);
    run_window(fill(255), 1'b1, 0);
    run_window(fill(100), 1'b0, 10);

    // abort a window part-way through accumulation
    ovr = 1'b0;
    out_ready = 1'b1;
    do_accept(rand_win(), ok);
    repeat (10) begin @(posedge clk); #1; end
    chk("flush_at_idx", rom_addr, 10);
    flush     = 1'b1;
    win_valid = 1'b1;
    win_data  = fill(7);
    @(posedge clk); #1;
    flush     = 1'b0;
    win_valid = 1'b0;
    chk("flush_state", {busy, out_valid, win_ready, out_pixel}, {1'b0, 1'b0, 1'b1, 8'd0});
    if (ok) void'(exp_q.pop_back());
    n = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid || busy) n++;
    end
    chk("flush_no_output", n, 0);
    run_window(fill(100), 1'b0, 0);

    // asynchronous reset while a result is waiting
    out_ready = 1'b0;
    do_accept(fill(50), ok);
    n = 0;
    while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
    chk("pre_reset_pixel", out_pixel, 50);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", {out_valid, out_pixel, win_ready, busy}, 0);
    if (ok) void'(exp_q.pop_back());
    @(posedge clk); #1;
    chk("win_ready_in_reset", win_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("win_ready_after_release", win_ready, 1);

    repeat (20) begin
      run_window(rand_win(), ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)));
    end

    repeat (3) @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
